// File: rtl/muldiv_hilo_pkg.sv
// muldiv_hilo_pkg: shared control codes, FSM states and op-class decode for the HI/LO unit.
package muldiv_hilo_pkg;

    localparam logic [7:0] MTHI  = 8'h11;
    localparam logic [7:0] MTLO  = 8'h13;
    localparam logic [7:0] MULT  = 8'h18;
    localparam logic [7:0] MULTU = 8'h19;
    localparam logic [7:0] DIV   = 8'h1a;
    localparam logic [7:0] DIVU  = 8'h1b;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    typedef enum logic [2:0] {OP_NONE, OP_MUL, OP_DIV, OP_MTHI, OP_MTLO} op_class_t;

    function automatic op_class_t op_class(input logic [7:0] c);
        return (c == MULT || c == MULTU) ? OP_MUL :
               (c == DIV || c == DIVU)   ? OP_DIV :
               (c == MTHI)               ? OP_MTHI :
               (c == MTLO)               ? OP_MTLO : OP_NONE;
    endfunction

    function automatic logic op_signed(input logic [7:0] c);
        return c == MULT || c == DIV;
    endfunction

endpackage

// File: rtl/muldiv_hilo_div_radix2.sv
// div_radix2: 32-step restoring divider on magnitudes with sign fix-up of quotient and remainder.
module div_radix2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        ready
);
    logic        busy, neg_q, neg_r;
    logic [4:0]  cnt;
    logic [31:0] q, r, d;
    logic [32:0] diff;

    assign diff      = {r, q[31]} - {1'b0, d};
    // ready flags the final iteration: results are valid after this edge
    assign ready     = busy & (cnt == 5'd31);
    assign quotient  = neg_q ? -q : q;
    assign remainder = neg_r ? -r : r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy  <= 1'b0;
            cnt   <= 5'd0;
            q     <= 32'd0;
            r     <= 32'd0;
            d     <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= 5'd0;
            r     <= 32'd0;
            q     <= (signed_op & a[31]) ? -a : a;
            d     <= (signed_op & b[31]) ? -b : b;
            neg_q <= signed_op & (a[31] ^ b[31]);
            neg_r <= signed_op & a[31];
        end else if (busy) begin
            cnt  <= cnt + 5'd1;
            busy <= cnt != 5'd31;
            r    <= diff[32] ? {r[30:0], q[31]} : diff[31:0];
            q    <= {q[30:0], ~diff[32]};
        end
    end
endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: execute-stage HI/LO unit with 2-cycle multiply, 34-cycle divide and MTHI/MTLO.
module muldiv_hilo
    import muldiv_hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        validE,
    input  logic        flushE,
    input  logic [7:0]  alucontrolE,
    input  logic [31:0] src_aE,
    input  logic [31:0] src_bE,
    output logic [63:0] hilo_out,
    output logic        stallE,
    output logic        doneE
);
    state_t            state, state_n;
    op_class_t         cls, op_cls;
    logic [7:0]        op_ctrl;
    logic signed [32:0] a_q, b_q;
    logic signed [63:0] prod_w;
    logic [63:0]       prod;
    logic [31:0]       hi, lo, quo, rem;
    logic              done_q, div_zero, accept, div_start, div_ready, sgn;

    assign cls       = op_class(alucontrolE);
    assign op_cls    = op_class(op_ctrl);
    assign sgn       = op_signed(alucontrolE);
    // done_q only blocks the instruction that just completed while it is still held
    assign accept    = rst & validE & ~flushE & (state == ST_IDLE) & ~(done_q & (alucontrolE == op_ctrl));
    assign div_start = accept & (cls == OP_DIV) & (src_bE != 32'd0);
    assign stallE    = (accept & (cls == OP_MUL || cls == OP_DIV)) | (state == ST_MUL) | (state == ST_DIV);
    assign doneE     = (state == ST_DONE) & ~flushE;
    assign prod_w    = 64'(a_q) * 64'(b_q);
    assign hilo_out  = {hi, lo};

    div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flushE),
        .signed_op (sgn),
        .a         (src_aE),
        .b         (src_bE),
        .quotient  (quo),
        .remainder (rem),
        .ready     (div_ready)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: state_n = !accept ? ST_IDLE :
                               cls == OP_MUL ? ST_MUL :
                               cls == OP_DIV ? (src_bE == 32'd0 ? ST_DONE : ST_DIV) : ST_IDLE;
            ST_MUL:  state_n = flushE ? ST_IDLE : ST_DONE;
            ST_DIV:  state_n = flushE ? ST_IDLE : div_ready ? ST_DONE : ST_DIV;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done_q   <= 1'b0;
            op_ctrl  <= 8'd0;
            a_q      <= 33'd0;
            b_q      <= 33'd0;
            prod     <= 64'd0;
            div_zero <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_ctrl  <= alucontrolE;
                a_q      <= {sgn & src_aE[31], src_aE};
                b_q      <= {sgn & src_bE[31], src_bE};
                div_zero <= (cls == OP_DIV) & (src_bE == 32'd0);
            end
            if (accept && cls == OP_MTHI)
                hi <= src_aE;
            if (accept && cls == OP_MTLO)
                lo <= src_aE;
            if (state == ST_MUL)
                prod <= prod_w;
            if (doneE && !div_zero) begin
                hi <= (op_cls == OP_MUL) ? prod[63:32] : rem;
                lo <= (op_cls == OP_MUL) ? prod[31:0]  : quo;
            end
            done_q <= doneE | (done_q & validE & (alucontrolE == op_ctrl));
        end
    end
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed vectors against a cycle-level behavioural model of the HI/LO unit.
module tb_muldiv_hilo;
    import muldiv_hilo_pkg::*;

    logic        clk = 1'b0, rst = 1'b0, validE = 1'b0, flushE = 1'b0;
    logic [7:0]  alucontrolE = 8'd0;
    logic [31:0] src_aE = 32'd0, src_bE = 32'd0;
    logic [63:0] hilo_out;
    logic        stallE, doneE;
    int          n_cmp = 0, n_bad = 0;

    muldiv_hilo dut (
        .clk         (clk),
        .rst         (rst),
        .validE      (validE),
        .flushE      (flushE),
        .alucontrolE (alucontrolE),
        .src_aE      (src_aE),
        .src_bE      (src_bE),
        .hilo_out    (hilo_out),
        .stallE      (stallE),
        .doneE       (doneE)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: results from plain arithmetic, timing as "done N cycles after accept".
    logic [63:0] m_hilo = 64'd0, m_res = 64'd0;
    logic        m_pend = 1'b0, m_wr = 1'b0, m_held = 1'b0, acc_m, long_m;
    logic [7:0]  m_op = 8'd0, m_held_op = 8'd0;
    int          cyc = 0, m_done_at = 0;
    longint      sa, sb, qq, rr;

    always @(negedge clk) begin
        check("hilo_out", hilo_out, m_hilo);
        if (!rst) begin
            m_hilo = 64'd0;
            m_pend = 1'b0;
            m_held = 1'b0;
        end else begin
            acc_m  = !m_pend && validE && !flushE && !(m_held && alucontrolE == m_held_op);
            long_m = alucontrolE inside {MULT, MULTU, DIV, DIVU};
            check("stallE", 64'(stallE), 64'(m_pend ? cyc < m_done_at : acc_m && long_m));
            check("doneE", 64'(doneE), 64'(m_pend && cyc == m_done_at && !flushE));
            if (m_pend && cyc == m_done_at && !flushE) begin
                if (m_wr) m_hilo = m_res;
                m_pend    = 1'b0;
                m_held    = 1'b1;
                m_held_op = m_op;
            end else begin
                if (m_pend && flushE) m_pend = 1'b0;
                if (!validE || alucontrolE != m_held_op) m_held = 1'b0;
            end
            if (acc_m) begin
                m_op = alucontrolE;
                case (alucontrolE)
                    MTHI: m_hilo[63:32] = src_aE;
                    MTLO: m_hilo[31:0]  = src_aE;
                    MULT, MULTU: begin
                        sa = (alucontrolE == MULT) ? longint'($signed(src_aE)) : longint'({32'd0, src_aE});
                        sb = (alucontrolE == MULT) ? longint'($signed(src_bE)) : longint'({32'd0, src_bE});
                        m_res = 64'(sa * sb);
                        m_pend = 1'b1;
                        m_wr = 1'b1;
                        m_done_at = cyc + 2;
                    end
                    DIV, DIVU: begin
                        m_pend = 1'b1;
                        m_wr = src_bE != 32'd0;
                        m_done_at = cyc + (m_wr ? 33 : 1);
                        if (m_wr) begin
                            sa = (alucontrolE == DIV) ? longint'($signed(src_aE)) : longint'({32'd0, src_aE});
                            sb = (alucontrolE == DIV) ? longint'($signed(src_bE)) : longint'({32'd0, src_bE});
                            qq = sa / sb;
                            rr = sa % sb;
                            m_res = {rr[31:0], qq[31:0]};
                        end
                    end
                    default: ;
                endcase
            end
        end
        cyc++;
    end

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output int stalls, output int dones);
        @(posedge clk); #2;
        validE = 1'b1; flushE = 1'b0; alucontrolE = op; src_aE = a; src_bE = b;
        stalls = 0; dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (stallE) stalls++;
            if (doneE) dones++;
            if (!stallE) return;
            @(posedge clk); #2;
            if (scramble) begin src_aE = $urandom; src_bE = $urandom; end
        end
        n_cmp++; n_bad++;
        $display("FAIL timeout: op %h still stalling", op);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #2;
        validE = 1'b0; flushE = 1'b0; alucontrolE = 8'd0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic op_check(input string name, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit scramble, input int exp_stalls,
                            input int exp_dones, input logic [63:0] exp_hilo);
        int st, dn;
        issue(op, a, b, scramble, st, dn);
        check({name, "_stalls"}, 64'(st), 64'(exp_stalls));
        check({name, "_dones"}, 64'(dn), 64'(exp_dones));
        idle(1);
        check({name, "_hilo"}, hilo_out, exp_hilo);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset_hilo", hilo_out, 64'd0);
        check("reset_stall", 64'(stallE), 64'd0);
        check("reset_done", 64'(doneE), 64'd0);

        // first edge with rst released accepts an operation
        rst = 1'b1; validE = 1'b1; alucontrolE = MTHI; src_aE = 32'hDEADBEEF;
        @(negedge clk);
        check("mthi_stall", 64'(stallE), 64'd0);
        idle(1);
        check("mthi_hilo", hilo_out, 64'hDEADBEEF_00000000);

        op_check("mult",   MULT,  32'hFFFFFFFE, 32'd3,        0, 2,  1, 64'hFFFFFFFF_FFFFFFFA);
        op_check("multu",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 2,  1, 64'hFFFFFFFE_00000001);
        op_check("divu",   DIVU,  32'd100,      32'd7,        0, 33, 1, 64'h00000002_0000000E);
        op_check("div_neg",DIV,   32'hFFFFFFF9, 32'd2,        0, 33, 1, 64'hFFFFFFFF_FFFFFFFD);
        op_check("div_ovf",DIV,   32'h80000000, 32'hFFFFFFFF, 0, 33, 1, 64'h00000000_80000000);
        op_check("div_z",  DIV,   32'd5,        32'd0,        0, 1,  1, 64'h00000000_80000000);
        op_check("divu_hold", DIVU, 32'd1000,   32'd10,       1, 33, 1, 64'h00000000_00000064);
        op_check("div_nb", DIV,   32'd7,        32'hFFFFFFFE, 0, 33, 1, 64'h00000001_FFFFFFFD);

        // flush at the tenth divide iteration
        @(posedge clk); #2;
        validE = 1'b1; alucontrolE = DIVU; src_aE = 32'd1000; src_bE = 32'd3;
        repeat (10) @(posedge clk);
        #2 flushE = 1'b1;
        @(posedge clk); #2;
        validE = 1'b0; flushE = 1'b0;
        @(negedge clk);
        check("flush_stall", 64'(stallE), 64'd0);
        check("flush_done", 64'(doneE), 64'd0);
        check("flush_hilo", hilo_out, 64'h00000001_FFFFFFFD);
        op_check("mtlo", MTLO, 32'h1234, 32'd0, 0, 0, 0, 64'h00000001_00001234);

        // completed MULT held valid must not run again
        begin
            int st, dn, extra;
            issue(MULT, 32'd3, 32'd4, 0, st, dn);
            extra = 0;
            repeat (5) begin
                @(negedge clk);
                if (stallE || doneE) extra++;
            end
            check("held_reissue", 64'(extra), 64'd0);
            idle(1);
            check("held_hilo", hilo_out, 64'h00000000_0000000C);
        end

        // flush coincident with accept: nothing starts
        @(posedge clk); #2;
        validE = 1'b1; flushE = 1'b1; alucontrolE = MULT; src_aE = 32'd7; src_bE = 32'd7;
        @(negedge clk);
        check("flush_acc_stall", 64'(stallE), 64'd0);
        idle(3);
        check("flush_acc_hilo", hilo_out, 64'h00000000_0000000C);

        // flush in DONE suppresses the write
        @(posedge clk); #2;
        validE = 1'b1; alucontrolE = MULT; src_aE = 32'd5; src_bE = 32'd5;
        @(posedge clk);
        @(posedge clk); #2 flushE = 1'b1;
        @(negedge clk);
        check("flush_done_pulse", 64'(doneE), 64'd0);
        idle(2);
        check("flush_done_hilo", hilo_out, 64'h00000000_0000000C);

        // reset mid-divide
        @(posedge clk); #2;
        validE = 1'b1; alucontrolE = DIVU; src_aE = 32'd50; src_bE = 32'd7;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0; validE = 1'b0; alucontrolE = 8'd0;
        @(posedge clk); #2 rst = 1'b1;
        check("rst_mid_hilo", hilo_out, 64'd0);
        check("rst_mid_stall", 64'(stallE), 64'd0);
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
